// File: rtl/spi_device.sv
`default_nettype none
// ============================================================================
//  Module   : spi_device
//  Purpose  : SPI mode-0 peripheral (CPOL=0, CPHA=0, MSB first, 8-bit bytes).
//             The SPI pads are synchronized into the clk domain.
//             Received bytes are presented on rx_data with a one-clk
//             rx_strobe. Bytes to send back are loaded through a one-deep
//             holding register (tx_data/tx_strobe). When nothing is held at
//             the start of a byte slot, 8'h00 is sent.
//  Ports    : clk, reset         - system clock, synchronous active-high reset
//             spi_sck/cs/copi    - asynchronous SPI pad inputs
//             spi_cipo(_oe)      - serial data out and its pad output enable
//             cs                 - synchronized chip select (1 = deselected)
//             rx_data/rx_strobe  - last received byte and its update pulse
//             tx_data/tx_strobe  - byte to return and its load pulse
//  Revision : 1.0 - initial release
// ============================================================================
module spi_device #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       spi_copi,
  output logic       spi_cipo,
  output logic       spi_cipo_oe,
  output logic       cs,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  input  logic [7:0] tx_data,
  input  logic       tx_strobe
);

  // A chain shorter than two flops cannot resolve metastability, so clamp it.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic ST_DESELECTED = 1'b0;
  localparam logic ST_SHIFT      = 1'b1;

  // --------------------------------------------------------------------------
  // Pad synchronizers, preset to the idle bus levels
  // --------------------------------------------------------------------------
  logic [STAGES-1:0] sck_sync;
  logic [STAGES-1:0] cs_sync;
  logic [STAGES-1:0] copi_sync;
  logic              sck_dly;
  logic [STAGES-1:0] settle_sr;
  logic              armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      copi_sync <= '0;
      sck_dly   <= 1'b0;
      settle_sr <= '0;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[STAGES-2:0], spi_cs};
      copi_sync <= {copi_sync[STAGES-2:0], spi_copi};
      sck_dly   <= sck_sync[STAGES-1];
      settle_sr <= {settle_sr[STAGES-2:0], 1'b1};
      // The preset CS=1 in the chain is not a real observation of the pad.
      // Selection is only allowed once a genuine high has been seen, so a
      // CS held low across reset does not start a transfer mid-byte.
      if (settle_sr[STAGES-1] && cs_sync[STAGES-1]) begin
        armed <= 1'b1;
      end
    end
  end

  logic sck_s;
  logic cs_s;
  logic copi_s;
  logic sck_rise;
  logic sck_fall;

  assign sck_s    = sck_sync[STAGES-1];
  assign cs_s     = cs_sync[STAGES-1];
  assign copi_s   = copi_sync[STAGES-1];
  assign sck_rise = sck_s & ~sck_dly;
  assign sck_fall = ~sck_s & sck_dly;
  assign cs       = cs_s;

  // --------------------------------------------------------------------------
  // State machine: register / next state / outputs
  // --------------------------------------------------------------------------
  logic state;
  logic state_next;
  logic enter_shift;
  logic leave_shift;
  logic in_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_DESELECTED;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_DESELECTED: if (armed && !cs_s) state_next = ST_SHIFT;
      ST_SHIFT:      if (cs_s)           state_next = ST_DESELECTED;
      default:                           state_next = ST_DESELECTED;
    endcase
  end

  always_comb begin
    enter_shift = 1'b0;
    leave_shift = 1'b0;
    in_shift    = 1'b0;
    spi_cipo_oe = 1'b0;
    if (state == ST_SHIFT) begin
      spi_cipo_oe = 1'b1;
      leave_shift = (state_next == ST_DESELECTED);
      in_shift    = (state_next == ST_SHIFT);
    end else begin
      enter_shift = (state_next == ST_SHIFT);
    end
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] hold;
  logic       hold_valid;
  logic       load_pending;   // bit 7 sampled; reload tx on the next fall
  logic       tx_load;
  logic [7:0] rx_next;

  assign tx_load  = enter_shift | (in_shift & sck_fall & load_pending);
  assign rx_next  = {rx_shift[6:0], copi_s};
  assign spi_cipo = tx_shift[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt      <= 3'd0;
      rx_shift     <= 8'h00;
      rx_data      <= 8'h00;
      rx_strobe    <= 1'b0;
      tx_shift     <= 8'h00;
      hold         <= 8'h00;
      hold_valid   <= 1'b0;
      load_pending <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;

      if (leave_shift) begin
        // Any partial byte is dropped; the next selection starts at bit 0.
        bit_cnt      <= 3'd0;
        load_pending <= 1'b0;
        hold_valid   <= 1'b0;
      end else if (in_shift) begin
        if (sck_rise) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data      <= rx_next;
            rx_strobe    <= 1'b1;
            load_pending <= 1'b1;
          end
        end
        if (sck_fall) begin
          if (load_pending) begin
            load_pending <= 1'b0;
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
      end

      if (tx_load) begin
        tx_shift   <= hold_valid ? hold : 8'h00;
        hold_valid <= 1'b0;
      end

      // Placed last so a strobe coinciding with a load survives for the
      // next byte slot rather than being consumed or cleared.
      if (tx_strobe) begin
        hold       <= tx_data;
        hold_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_device.md
SPI_DEVICE -- requirements
Module: spi_device

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flop stages on each asynchronous pad input (minimum 2).
REQ-002 clk  input  1  system clock; all logic is in this single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 spi_sck  input  1  SPI serial clock pad, asynchronous to clk.
REQ-005 spi_cs  input  1  SPI chip-select pad, asynchronous to clk; high means deselected.
REQ-006 spi_copi  input  1  controller-out/peripheral-in data pad, asynchronous to clk.
REQ-007 spi_cipo  output  1  controller-in/peripheral-out data.
REQ-008 spi_cipo_oe  output  1  output enable for the spi_cipo pad driver; high means drive.
REQ-009 cs  output  1  synchronized chip-select; high means deselected; feeds the control block's spi_cs.
REQ-010 rx_data  output  8  last fully received byte.
REQ-011 rx_strobe  output  1  one-clk pulse when rx_data is updated.
REQ-012 tx_data  input  8  byte to return on the next byte slot.
REQ-013 tx_strobe  input  1  one-clk pulse that loads tx_data into the holding register.

Function
REQ-014 The SPI mode SHALL be 0 (CPOL=0, CPHA=0), MSB first, 8-bit bytes.
- spi_copi is sampled on the synchronized SCK rising edge.
- spi_cipo changes on the synchronized SCK falling edge.
REQ-015 spi_sck, spi_cs and spi_copi SHALL each pass through SYNC_STAGES flops.
- SCK edges are detected from one further registered stage, so each detected edge is a single-clk event.
REQ-016 The supported SCK high and low times SHALL each be at least 8 clk periods; behaviour outside this limit is undefined.
REQ-017 The state machine SHALL have two states, DESELECTED and SHIFT.
- DESELECTED -> SHIFT when synchronized CS goes low.
- SHIFT -> DESELECTED when synchronized CS goes high, from any bit position.
REQ-018 cs SHALL equal the synchronized spi_cs value.
REQ-019 In SHIFT, a 3-bit bit counter SHALL increment on each SCK rising edge and wrap from 7 to 0.
- Each rising edge shifts the sampled spi_copi into the LSB of the receive shift register.
REQ-020 On the rising edge that completes bit 7, the following SHALL happen on the next clk:
- rx_data takes the completed byte.
- rx_strobe is high for exactly that one clk.
REQ-021 A partial byte at CS deassertion SHALL be discarded, with no rx_strobe and the bit counter cleared to 0.
REQ-022 tx_strobe SHALL write tx_data into the holding register and set hold_valid.
- A strobe while hold_valid is already set overwrites the holding register; the last value wins.
REQ-023 The transmit shift register SHALL load at two points:
- on the transition into SHIFT;
- on the SCK falling edge that follows the bit-7 rising edge.
At each load it takes the holding register if hold_valid is set, otherwise 8'h00 (underrun), and hold_valid is cleared.
REQ-024 On every other SCK falling edge in SHIFT, the transmit shift register SHALL shift left with a 0 fill.
REQ-025 spi_cipo SHALL equal the transmit shift register MSB.
REQ-026 spi_cipo_oe SHALL be high only in SHIFT.
REQ-027 A tx_strobe arriving in the same clk as a shift-register load SHALL go to the holding register after the load, so it is used at the next byte slot.
REQ-028 Transition to DESELECTED SHALL clear hold_valid; a byte strobed while deselected is still held for the next selection.

Reset
REQ-029 Reset SHALL put the block into the following state:
- State DESELECTED, bit counter 0, hold_valid 0, shift registers 8'h00.
- Outputs: cs=1, rx_data=8'h00, rx_strobe=0, spi_cipo=0, spi_cipo_oe=0.
- Synchronizer flops preset to idle: SCK=0, CS=1, COPI=0.
REQ-030 Reset asserted mid-byte SHALL abandon the byte with no rx_strobe.
- After reset is released, the block waits for a fresh CS high-to-low transition before entering SHIFT.

Verification
REQ-031 Before CS falls, tx_strobe with 8'hA5; CS low; send 8'h3C -> controller receives 8'hA5 on spi_cipo; rx_data=8'h3C; exactly one rx_strobe.
REQ-032 Send 8'h12 with no tx_strobe; 3 clks after rx_strobe, tx_strobe 8'h5A; send a second byte -> first byte returns 8'h00; second returns 8'h5A.
REQ-033 CS deasserted after 5 bits -> no rx_strobe; cs=1 within SYNC_STAGES+1 clks; next full byte 8'hF0 is received correctly from bit 0.
REQ-034 Two tx_strobes, 8'h11 then 8'h22, before one byte slot -> 8'h22 transmitted; the following slot returns 8'h00.
REQ-035 Reset pulsed during bit 3 of a byte with CS held low -> outputs at reset values; no rx_strobe until CS toggles high then low and a full byte is sent.
REQ-036 SCK at its minimum high and low time of 8 clk each, 16 back-to-back bytes 8'h00..8'h0F -> all received in order, one rx_strobe per byte.
